serial_sub: RTL and testbench
=============================

# serial_sub

Bit-serial unsigned/two's-complement subtractor, the inverse-direction companion of the ripple full-adder datapath in the ALU. It computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow, which trades latency for area. It sits beside the combinational adder path as the multi-cycle SUB unit, with a start/busy/done handshake toward the ALU controller.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range 2..32.

- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; accepted only in IDLE or DONE.
- `a`  in  WIDTH  minuend; sampled on the accepting edge only.
- `b`  in  WIDTH  subtrahend; sampled on the accepting edge only.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; `d` and `bo` are valid from this cycle on.
- `d`  out  WIDTH  difference, `(a - b) mod 2^WIDTH`.
- `bo`  out  1  final borrow; 1 iff `a < b` unsigned.
- `ovf`  out  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
  - IDLE: on `start`, latch `a` and `b` into shift registers, clear the borrow flop and the bit counter, and go to RUN.
  - RUN: each cycle, take bit i of each operand and compute:
    - `di = ai ^ bi ^ br`
    - `br' = (~ai & bi) | (~(ai ^ bi) & br)`
  - RUN, continued: shift `di` into the internal result register MSB-first-arrival (right shift), then increment the counter. After the edge that processes bit WIDTH-1, load `d` from the completed internal register, load `bo` from the final borrow, and go to DONE.
  - DONE: `done` is 1 for exactly this cycle. With `start` asserted, behave as IDLE+start and go to RUN. Otherwise go to IDLE.
- `d` and `bo` change only on the completion edge. They hold their values through IDLE and any following RUN until the next completion.
- `start` in RUN is ignored. There is no queueing and no error flag.
- `a` and `b` may change freely after the accepting edge.
- The counter is `$clog2(WIDTH+1)` bits wide and never wraps in normal operation.

## Timing
- Reset value of all state and outputs:
  - state = IDLE
  - `busy` = 0
  - `done` = 0
  - `d` = 0
  - `bo` = 0
  - `ovf` = 0
- Reset has priority over `start`. Reset during RUN aborts the operation; no partial result is visible.
- Latency: for `start` sampled at edge E0, `busy` is high from E0 to E(WIDTH). `done`, `d` and `bo` take their new values at edge E(WIDTH).
- Throughput: one result per WIDTH+1 cycles, since `start` is accepted in the DONE cycle.
- `busy` and `done` are never high in the same cycle. `busy` is low in IDLE and DONE.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - The `ovf` port and register exist.
  - At the completion edge, `ovf = (a[W-1] != b[W-1]) & (d[W-1] != a[W-1])`, using the latched operand sign bits.
  - `ovf` holds until the next completion and resets to 0.
- `SERIAL_SUB_OVF_EN` undefined: the `ovf` port is absent and the sign-bit latches are removed. All other behaviour is identical.

## Test plan
- Basic subtraction: WIDTH=4, a=7, b=3, start at E0 → `busy` high for 4 cycles; at E4, `done`=1, `d`=4'h4, `bo`=0.
- Borrow: a=3, b=7 → `d`=4'hC, `bo`=1. Then a=0, b=0 → `d`=0, `bo`=0. Then a=4'hF, b=4'hF → `d`=0, `bo`=0.
- Start while busy: pulse `start` at E2 of an operation with a=9, b=2 → that pulse is ignored. At E4, `d`=7, then the block returns to IDLE with no second `done`.
- Back-to-back: `start` in the DONE cycle with a=5, b=6 → `busy` again from the next cycle; at E4 of the new operation, `d`=4'hF, `bo`=1. The previous result holds until then.
- Reset mid-operation: assert `reset` at E2 → IDLE and all outputs 0 on the following cycle; no `done`. A subsequent a=1, b=1 returns `d`=0 after 4 cycles.
- Overflow, with `SERIAL_SUB_OVF_EN`:
  - a=4'h8, b=4'h1 → `d`=4'h7, `bo`=0, `ovf`=1.
  - a=4'h2, b=4'h1 → `ovf`=0.
  - Build again with the macro undefined and confirm the port is absent.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, with a registered borrow.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
module serial_sub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bo_q, bo_d;

    logic ai, bi, di, br_next;
    logic [WIDTH-1:0] res_shifted;

`ifdef SERIAL_SUB_OVF_EN
    logic a_sign_q, a_sign_d;
    logic b_sign_q, b_sign_d;
    logic ovf_q, ovf_d;
`endif

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    assign ai          = a_sh_q[0];
    assign bi          = b_sh_q[0];
    assign di          = ai ^ bi ^ br_q;
    assign br_next     = (~ai & bi) | (~(ai ^ bi) & br_q);
    assign res_shifted = {di, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bo_d    = bo_q;
`ifdef SERIAL_SUB_OVF_EN
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                    a_sign_d = a[WIDTH-1];
                    b_sign_d = b[WIDTH-1];
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_shifted;
                br_d   = br_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    d_d     = res_shifted;
                    bo_d    = br_next;
`ifdef SERIAL_SUB_OVF_EN
                    // di is the MSB of the finished difference here.
                    ovf_d = (a_sign_q != b_sign_q) & (di != a_sign_q);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bo_q    <= bo_d;
`ifdef SERIAL_SUB_OVF_EN
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign d    = d_q;
    assign bo   = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Randomised self-checking bench for serial_sub against an arithmetic reference model.
module tb_serial_sub;

    localparam int unsigned W = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bo;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Expected held result (last completed operation).
    logic [W-1:0] exp_d;
    logic         exp_bo;
    logic         exp_ovf;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bo    (bo)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_held(input string tag);
        check({tag, ".d"}, 32'(d), 32'(exp_d));
        check({tag, ".bo"}, 32'(bo), 32'(exp_bo));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    // Reference: plain integer subtraction, unsigned and signed views.
    task automatic model(input logic [W-1:0] oa, input logic [W-1:0] ob);
        int ua, ub, sa, sb, r;
        ua = int'(oa);
        ub = int'(ob);
        sa = oa[W-1] ? ua - (1 << W) : ua;
        sb = ob[W-1] ? ub - (1 << W) : ub;
        r  = sa - sb;
        exp_d   = W'((ua - ub + (1 << W)) % (1 << W));
        exp_bo  = (ua < ub);
        exp_ovf = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endtask

    // Starts an operation (from IDLE or DONE) and ends sampling the DONE cycle.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input bit mid_start);
        start = 1'b1;
        a     = oa;
        b     = ob;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        check("run.busy0", 32'(busy), 32'd1);
        check("run.done0", 32'(done), 32'd0);
        for (int k = 1; k < int'(W); k++) begin
            if (mid_start && k == 2) start = 1'b1;
            tick();
            start = 1'b0;
            check("run.busy", 32'(busy), 32'd1);
            check("run.done", 32'(done), 32'd0);
            check_held("run.hold");
        end
        tick();
        model(oa, ob);
        check("fin.done", 32'(done), 32'd1);
        check("fin.busy", 32'(busy), 32'd0);
        check_held("fin");
    endtask

    task automatic go_idle();
        tick();
        check("idle.done", 32'(done), 32'd0);
        check("idle.busy", 32'(busy), 32'd0);
        check_held("idle");
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        reset   = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        exp_d   = '0;
        exp_bo  = 1'b0;
        exp_ovf = 1'b0;
        repeat (2) tick();
        // Start during reset must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check_held("rst");

        run_op(4'h7, 4'h3, 1'b0); go_idle();
        run_op(4'h3, 4'h7, 1'b0); go_idle();
        run_op(4'h0, 4'h0, 1'b0); go_idle();
        run_op(4'hF, 4'hF, 1'b0); go_idle();

        // Start while busy is ignored; no second done afterwards.
        run_op(4'h9, 4'h2, 1'b1);
        go_idle();
        go_idle();

        // Back-to-back: start in the DONE cycle.
        run_op(4'hA, 4'h1, 1'b0);
        run_op(4'h5, 4'h6, 1'b0);
        go_idle();

        // Reset mid-operation, sampled at E2.
        start = 1'b1;
        a     = 4'h6;
        b     = 4'h1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        exp_d   = '0;
        exp_bo  = 1'b0;
        exp_ovf = 1'b0;
        check("mrst.busy", 32'(busy), 32'd0);
        check("mrst.done", 32'(done), 32'd0);
        check_held("mrst");
        go_idle();
        run_op(4'h1, 4'h1, 1'b0); go_idle();

        run_op(4'h8, 4'h1, 1'b0); go_idle();
        run_op(4'h2, 4'h1, 1'b0); go_idle();
        run_op(4'h7, 4'hF, 1'b0); go_idle();

        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) go_idle();
        end
        go_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
